multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 185 ++++++++++++++++++
 tb/tb_multiport_register_file.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Two-read / two-write register file with a power-up clear sequence,
// write-to-read forwarding, a pending scoreboard and a raw debug port.
module multiport_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  Ready,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   input  logic                  WriteEnableA,
   input  logic [ADDR_WIDTH-1:0] WriteRegisterA,
   input  logic [DATA_WIDTH-1:0] WriteDataA,
   input  logic                  WriteEnableB,
   input  logic [ADDR_WIDTH-1:0] WriteRegisterB,
   input  logic [DATA_WIDTH-1:0] WriteDataB,
   input  logic                  ReserveEnable,
   input  logic [ADDR_WIDTH-1:0] ReserveRegister,
   output logic                  Pending1,
   output logic                  Pending2,
   input  logic [ADDR_WIDTH-1:0] DebugRegister,
   output logic [DATA_WIDTH-1:0] DebugData,
   output logic                  Collision
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t state;
   state_t nextState;

   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      pending;
   logic [DEPTH-1:0]      setMask;
   logic [DEPTH-1:0]      clrMask;

   logic wrA;
   logic wrB;
   logic rsv;
   logic hitA1;
   logic hitB1;
   logic hitA2;
   logic hitB2;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
      end else begin
         state <= nextState;
      end
   end

   // FSM: next state
   always_comb begin
      nextState = state;
      case (state)
         CLEAR:   if (cnt == LAST) nextState = RUN;
         RUN:     nextState = RUN;
         default: nextState = CLEAR;
      endcase
   end

   // FSM: outputs
   always_comb begin
      Ready = (state == RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + ADDR_WIDTH'(1);
      end
   end

   // Address 0 is dropped as a target when it is hardwired to zero
   always_comb begin
      wrA = Ready && WriteEnableA
            && !(ZERO_REG && WriteRegisterA == '0);
      wrB = Ready && WriteEnableB
            && !(ZERO_REG && WriteRegisterB == '0);
      rsv = Ready && ReserveEnable
            && !(ZERO_REG && ReserveRegister == '0);
   end

   // Port B is written last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) begin
            regs[cnt] <= '0;
         end else begin
            if (wrA) regs[WriteRegisterA] <= WriteDataA;
            if (wrB) regs[WriteRegisterB] <= WriteDataB;
         end
      end
   end

   always_comb begin
      setMask = rsv ? (ONE << ReserveRegister) : '0;
      clrMask = '0;
      if (wrA) clrMask = clrMask | (ONE << WriteRegisterA);
      if (wrB) clrMask = clrMask | (ONE << WriteRegisterB);
   end

   // Set is applied after clear so a same-cycle reserve survives a write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clrMask) | setMask;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Collision <= 1'b0;
      end else begin
         Collision <= Ready && WriteEnableA && WriteEnableB
                      && (WriteRegisterA == WriteRegisterB);
      end
   end

   always_comb begin
      hitA1 = BYPASS && WriteEnableA
              && (WriteRegisterA == ReadRegister1);
      hitB1 = BYPASS && WriteEnableB
              && (WriteRegisterB == ReadRegister1);
      hitA2 = BYPASS && WriteEnableA
              && (WriteRegisterA == ReadRegister2);
      hitB2 = BYPASS && WriteEnableB
              && (WriteRegisterB == ReadRegister2);
   end

   always_comb begin
      ReadData1 = regs[ReadRegister1];
      if (hitB1) begin
         ReadData1 = WriteDataB;
      end else if (hitA1) begin
         ReadData1 = WriteDataA;
      end
      if (!Ready || (ZERO_REG && ReadRegister1 == '0)) begin
         ReadData1 = '0;
      end
   end

   always_comb begin
      ReadData2 = regs[ReadRegister2];
      if (hitB2) begin
         ReadData2 = WriteDataB;
      end else if (hitA2) begin
         ReadData2 = WriteDataA;
      end
      if (!Ready || (ZERO_REG && ReadRegister2 == '0)) begin
         ReadData2 = '0;
      end
   end

   always_comb begin
      DebugData = regs[DebugRegister];
      if (!Ready || (ZERO_REG && DebugRegister == '0)) begin
         DebugData = '0;
      end
   end

   always_comb begin
      Pending1 = Ready && pending[ReadRegister1]
                 && !(hitA1 || hitB1);
      Pending2 = Ready && pending[ReadRegister2]
                 && !(hitA2 || hitB2);
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: clear sequence, forwarding,
// collisions, zero register, pending scoreboard and mid-clear reset.
module tb_multiport_register_file;

   logic        clk;
   logic        rst_n;
   logic        Ready;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        WriteEnableA;
   logic [4:0]  WriteRegisterA;
   logic [31:0] WriteDataA;
   logic        WriteEnableB;
   logic [4:0]  WriteRegisterB;
   logic [31:0] WriteDataB;
   logic        ReserveEnable;
   logic [4:0]  ReserveRegister;
   logic        Pending1;
   logic        Pending2;
   logic [4:0]  DebugRegister;
   logic [31:0] DebugData;
   logic        Collision;

   logic        nbReady;
   logic [31:0] nbReadData1;
   logic [31:0] nbReadData2;
   logic        nbPending1;
   logic        nbPending2;
   logic [31:0] nbDebugData;
   logic        nbCollision;

   int nAsserts = 0;
   int nFails   = 0;
   int edges;
   logic allOk;

   multiport_register_file dut (
      .clk(clk), .rst_n(rst_n), .Ready(Ready),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteEnableA(WriteEnableA), .WriteRegisterA(WriteRegisterA),
      .WriteDataA(WriteDataA),
      .WriteEnableB(WriteEnableB), .WriteRegisterB(WriteRegisterB),
      .WriteDataB(WriteDataB),
      .ReserveEnable(ReserveEnable), .ReserveRegister(ReserveRegister),
      .Pending1(Pending1), .Pending2(Pending2),
      .DebugRegister(DebugRegister), .DebugData(DebugData),
      .Collision(Collision)
   );

   multiport_register_file #(.BYPASS(1'b0)) dutNb (
      .clk(clk), .rst_n(rst_n), .Ready(nbReady),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(nbReadData1), .ReadData2(nbReadData2),
      .WriteEnableA(WriteEnableA), .WriteRegisterA(WriteRegisterA),
      .WriteDataA(WriteDataA),
      .WriteEnableB(WriteEnableB), .WriteRegisterB(WriteRegisterB),
      .WriteDataB(WriteDataB),
      .ReserveEnable(ReserveEnable), .ReserveRegister(ReserveRegister),
      .Pending1(nbPending1), .Pending2(nbPending2),
      .DebugRegister(DebugRegister), .DebugData(nbDebugData),
      .Collision(nbCollision)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      WriteEnableA  = 1'b0;
      WriteEnableB  = 1'b0;
      ReserveEnable = 1'b0;
   endtask

   // Counts edges with rst_n high until Ready, checking quiet outputs
   task automatic waitReady(output int n, output logic ok);
      n  = 0;
      ok = 1'b1;
      while (!Ready && n < 40) begin
         if (ReadData1 !== 0 || ReadData2 !== 0 || DebugData !== 0
             || Pending1 !== 0 || Pending2 !== 0 || Collision !== 0
             || nbReadData1 !== 0 || nbReady !== 0)
            ok = 1'b0;
         tick();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      ReadRegister1   = '0;
      ReadRegister2   = '0;
      WriteRegisterA  = '0;
      WriteRegisterB  = '0;
      WriteDataA      = '0;
      WriteDataB      = '0;
      ReserveRegister = '0;
      DebugRegister   = '0;
      tick();
      tick();
      chk("reset_ready", 32'(Ready), 32'd0);
      chk("reset_collision", 32'(Collision), 32'd0);
      chk("reset_rd1", ReadData1, 32'd0);

      // Writes, collisions and reserves during clear must be ignored
      WriteEnableA    = 1'b1;
      WriteRegisterA  = 5'd3;
      WriteDataA      = 32'hAAAA_AAAA;
      WriteEnableB    = 1'b1;
      WriteRegisterB  = 5'd3;
      WriteDataB      = 32'hBBBB_BBBB;
      ReserveEnable   = 1'b1;
      ReserveRegister = 5'd3;
      ReadRegister1   = 5'd3;
      ReadRegister2   = 5'd3;
      DebugRegister   = 5'd3;
      rst_n = 1'b1;
      #1;
      waitReady(edges, allOk);
      idle();
      #1;
      chk("clear_cycles", 32'(edges), 32'd32);
      chk("clear_quiet", 32'(allOk), 32'd1);
      chk("nb_ready", 32'(nbReady), 32'd1);
      chk("clear_r3", ReadData1, 32'd0);
      chk("clear_pend", 32'(Pending1), 32'd0);
      chk("clear_coll", 32'(Collision), 32'd0);
      allOk = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         DebugRegister = 5'(i);
         #1;
         if (ReadData1 !== 0 || DebugData !== 0 || nbReadData1 !== 0)
            allOk = 1'b0;
      end
      chk("all_zero", 32'(allOk), 32'd1);

      // Forwarding: A writes r5
      ReadRegister1  = 5'd5;
      DebugRegister  = 5'd5;
      WriteEnableA   = 1'b1;
      WriteRegisterA = 5'd5;
      WriteDataA     = 32'hDEAD_BEEF;
      #1;
      chk("byp_same", ReadData1, 32'hDEAD_BEEF);
      chk("nb_same", nbReadData1, 32'd0);
      chk("dbg_nobyp", DebugData, 32'd0);
      tick();
      idle();
      #1;
      chk("byp_next", ReadData1, 32'hDEAD_BEEF);
      chk("nb_next", nbReadData1, 32'hDEAD_BEEF);
      chk("dbg_next", DebugData, 32'hDEAD_BEEF);

      // Same-address collision: B wins, flag for one cycle
      ReadRegister2  = 5'd7;
      WriteEnableA   = 1'b1;
      WriteRegisterA = 5'd7;
      WriteDataA     = 32'h1;
      WriteEnableB   = 1'b1;
      WriteRegisterB = 5'd7;
      WriteDataB     = 32'h2;
      #1;
      chk("byp_bprio", ReadData2, 32'h2);
      chk("coll_before", 32'(Collision), 32'd0);
      tick();
      idle();
      #1;
      chk("coll_r7", ReadData2, 32'h2);
      chk("coll_r7_nb", nbReadData2, 32'h2);
      chk("coll_set", 32'(Collision), 32'd1);
      tick();
      chk("coll_clear", 32'(Collision), 32'd0);

      // Two distinct writes in one cycle
      WriteEnableA   = 1'b1;
      WriteRegisterA = 5'd10;
      WriteDataA     = 32'h11;
      WriteEnableB   = 1'b1;
      WriteRegisterB = 5'd11;
      WriteDataB     = 32'h22;
      tick();
      idle();
      ReadRegister1 = 5'd10;
      ReadRegister2 = 5'd11;
      #1;
      chk("dual_r10", ReadData1, 32'h11);
      chk("dual_r11", ReadData2, 32'h22);
      chk("dual_nocoll", 32'(Collision), 32'd0);

      // Zero register
      ReadRegister1  = 5'd0;
      ReadRegister2  = 5'd0;
      DebugRegister  = 5'd0;
      WriteEnableA   = 1'b1;
      WriteRegisterA = 5'd0;
      WriteDataA     = 32'hFFFF_FFFF;
      #1;
      chk("zero_byp", ReadData1, 32'd0);
      tick();
      idle();
      #1;
      chk("zero_rd1", ReadData1, 32'd0);
      chk("zero_rd2", ReadData2, 32'd0);
      chk("zero_dbg", DebugData, 32'd0);
      chk("zero_nb", nbDebugData, 32'd0);

      // Pending scoreboard on r9
      ReadRegister1   = 5'd9;
      ReadRegister2   = 5'd10;
      ReserveEnable   = 1'b1;
      ReserveRegister = 5'd9;
      #1;
      chk("pend_pre", 32'(Pending1), 32'd0);
      tick();
      idle();
      #1;
      chk("pend_set", 32'(Pending1), 32'd1);
      chk("pend_other", 32'(Pending2), 32'd0);
      WriteEnableB   = 1'b1;
      WriteRegisterB = 5'd9;
      WriteDataB     = 32'h99;
      #1;
      chk("pend_fwd", 32'(Pending1), 32'd0);
      chk("pend_fwd_nb", 32'(nbPending1), 32'd1);
      tick();
      idle();
      #1;
      chk("pend_clr", 32'(Pending1), 32'd0);
      chk("pend_clr_nb", 32'(nbPending1), 32'd0);
      tick();
      chk("pend_stay", 32'(Pending1), 32'd0);
      ReserveEnable   = 1'b1;
      ReserveRegister = 5'd9;
      WriteEnableA    = 1'b1;
      WriteRegisterA  = 5'd9;
      WriteDataA      = 32'h77;
      tick();
      idle();
      #1;
      chk("pend_rsv_wins", 32'(Pending1), 32'd1);
      chk("pend_rsv_data", ReadData1, 32'h77);
      ReserveEnable   = 1'b1;
      ReserveRegister = 5'd0;
      ReadRegister2   = 5'd0;
      tick();
      idle();
      #1;
      chk("pend_r0", 32'(Pending2), 32'd0);

      // Reset mid-clear restarts the full sequence
      WriteEnableA   = 1'b1;
      WriteRegisterA = 5'd20;
      WriteDataA     = 32'h55;
      tick();
      idle();
      ReadRegister1 = 5'd20;
      #1;
      chk("r20_written", ReadData1, 32'h55);
      rst_n = 1'b0;
      tick();
      chk("rst_run_ready", 32'(Ready), 32'd0);
      chk("rst_run_pend", 32'(Pending1), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("mid_clear_ready", 32'(Ready), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      waitReady(edges, allOk);
      chk("restart_cycles", 32'(edges), 32'd32);
      chk("restart_quiet", 32'(allOk), 32'd1);
      chk("r20_cleared", ReadData1, 32'd0);
      ReadRegister1 = 5'd9;
      #1;
      chk("r9_cleared", ReadData1, 32'd0);
      chk("r9_pend_cleared", 32'(Pending1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAsserts, nFails);
      $finish;
   end

endmodule
